// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel valid/ready multiplexer family.
package mux_pkg;

    localparam logic MODE_STATIC = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Channel-index width; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: highest priority goes to the channel after last.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int SW   = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SW-1:0]   last,
    input  logic            en,
    output logic [N_CH-1:0] gnt
);

    logic [SW-1:0]     start;
    logic [N_CH-1:0]   rot;
    logic [N_CH-1:0]   pe;
    logic [2*N_CH-1:0] gnt_dbl;
    logic              found;

    always_comb begin
        start = (int'(last) >= N_CH - 1) ? '0 : last + SW'(1);
        // Shifting the doubled vector rotates correctly even when N_CH is not a power of 2.
        rot   = N_CH'({req, req} >> start);

        pe    = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (rot[k] && !found) begin
                pe[k] = 1'b1;
                found = 1'b1;
            end
        end

        gnt_dbl = {{N_CH{1'b0}}, pe} << start;
        gnt     = en ? (gnt_dbl[2*N_CH-1:N_CH] | gnt_dbl[N_CH-1:0]) : '0;
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// N:1 valid/ready multiplexer with static or round-robin selection and a registered output.
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    parameter int SW   = ch_width(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH*DW-1:0] in_data,
    input  logic [N_CH-1:0]    in_valid,
    output logic [N_CH-1:0]    in_ready,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    output logic [DW-1:0]      out_data,
    output logic [SW-1:0]      out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic            ld;
    logic [N_CH-1:0] sel_gnt;
    logic [N_CH-1:0] rr_gnt;
    logic [N_CH-1:0] gnt;
    logic [SW-1:0]   last;
    logic [SW-1:0]   gnt_idx;
    logic [DW-1:0]   gnt_data;

    assign ld = !out_valid || out_ready;

    always_comb begin
        sel_gnt = '0;
        if (mode == MODE_STATIC && int'(sel) < N_CH) begin
            sel_gnt[sel] = in_valid[sel];
        end
    end

    rr_arbiter #(
        .N_CH (N_CH),
        .SW   (SW)
    ) u_arb (
        .req  (in_valid),
        .last (last),
        .en   (mode == MODE_RR),
        .gnt  (rr_gnt)
    );

    assign gnt      = sel_gnt | rr_gnt;
    // Gated by reset so no channel sees a handshake while the output stage is being cleared.
    assign in_ready = (rst_n && ld) ? gnt : '0;

    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                gnt_idx  = SW'(i);
                gnt_data = in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            last      <= SW'(N_CH - 1);
        end else if (ld) begin
            if (|gnt) begin
                out_data  <= gnt_data;
                out_ch    <= gnt_idx;
                out_valid <= 1'b1;
                if (mode == MODE_RR) begin
                    last <= gnt_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Drives a 4-channel and a 3-channel mux from shared stimulus and compares both to a reference model.
module tb_mux_nx1_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic        mode;
    logic [1:0]  sel;
    logic        out_ready;

    logic [3:0]  rdy4;
    logic [7:0]  out_data4;
    logic [1:0]  out_ch4;
    logic        out_valid4;
    logic [2:0]  rdy3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;

    int errors = 0;
    int checks = 0;

    // Reference state per instance: index 0 is the 4-channel DUT, 1 the 3-channel one.
    int         nch [2] = '{4, 3};
    logic       mv  [2] = '{1'b0, 1'b0};
    logic [7:0] md  [2] = '{8'h00, 8'h00};
    int         mc  [2] = '{0, 0};
    int         ml  [2] = '{3, 2};

    always #5 clk = ~clk;

    mux_nx1_rr #(.N_CH(4), .DW(8)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (rdy4),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data4),
        .out_ch    (out_ch4),
        .out_valid (out_valid4),
        .out_ready (out_ready)
    );

    mux_nx1_rr #(.N_CH(3), .DW(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data[23:0]),
        .in_valid  (in_valid[2:0]),
        .in_ready  (rdy3),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
        .out_valid (out_valid3),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel the consumer would receive from, or all-zero when nobody may transfer.
    function automatic logic [3:0] exp_ready(input int j);
        logic [3:0] e = '0;
        int n = nch[j];
        if (!rst_n || (mv[j] && !out_ready)) return '0;
        if (mode == 1'b0) begin
            if (int'(sel) < n && in_valid[sel]) e[sel] = 1'b1;
        end else begin
            for (int k = 1; k <= n; k++) begin
                int i = (ml[j] + k) % n;
                if (in_valid[i]) begin
                    e[i] = 1'b1;
                    break;
                end
            end
        end
        return e;
    endfunction

    task automatic step();
        logic [3:0] e [2];
        @(negedge clk);
        e[0] = exp_ready(0);
        e[1] = exp_ready(1);
        check("ready4", {28'd0, rdy4}, {28'd0, e[0]});
        check("ready3", {28'd0, 1'b0, rdy3}, {28'd0, e[1]});
        for (int j = 0; j < 2; j++) begin
            if (!rst_n) begin
                mv[j] = 1'b0;
                md[j] = 8'h00;
                mc[j] = 0;
                ml[j] = nch[j] - 1;
            end else if (!mv[j] || out_ready) begin
                if (e[j] != 4'b0000) begin
                    int i = 0;
                    for (int k = 0; k < 4; k++) if (e[j][k]) i = k;
                    md[j] = in_data[i*8 +: 8];
                    mc[j] = i;
                    mv[j] = 1'b1;
                    if (mode) ml[j] = i;
                end else begin
                    mv[j] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        check("valid4", {31'd0, out_valid4}, {31'd0, mv[0]});
        check("data4",  {24'd0, out_data4},  {24'd0, md[0]});
        check("ch4",    {30'd0, out_ch4},    32'(mc[0]));
        check("valid3", {31'd0, out_valid3}, {31'd0, mv[1]});
        check("data3",  {24'd0, out_data3},  {24'd0, md[1]});
        check("ch3",    {30'd0, out_ch3},    32'(mc[1]));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = $urandom;
        in_valid  = 4'b1111;
        mode      = 1'b1;
        sel       = 2'd0;
        out_ready = 1'b1;
        repeat (2) step();

        rst_n = 1'b1;
        step();

        mode    = 1'b0;
        sel     = 2'd2;
        in_data = {8'h11, 8'hA5, 8'h22, 8'h33};
        step();
        sel     = 2'd3;
        in_data = {8'h3C, 8'h44, 8'h55, 8'h66};
        step();
        step();

        mode = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_data = $urandom;
            step();
        end
        in_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            in_data = $urandom;
            step();
        end

        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_data = $urandom;
            step();
        end
        out_ready = 1'b1;
        step();

        in_valid = 4'b1000;
        step();
        in_valid = 4'b0001;
        step();
        in_valid = 4'b0000;
        step();
        step();

        in_valid = 4'b1111;
        step();
        out_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        step();

        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(0, 29) != 0);
            in_data   = $urandom;
            in_valid  = 4'($urandom);
            mode      = ($urandom_range(0, 3) != 0);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
